// File: rtl/data_interpolation.sv
// Stream upsampler: each accepted input sample becomes interp_reg+1 output beats.
// Build option DATA_INTERP_ZERO_STUFF_EN selects zero-stuffing; default is sample-and-hold.
module data_interpolation #(
  parameter int DATA_IN_WIDTH  = 12,
  parameter int DATA_OUT_WIDTH = 12,
  parameter int DATA_REG_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_data_valid,
  output logic                      in_data_ready,
  input  logic [DATA_IN_WIDTH-1:0]  in_data,
  output logic                      out_data_valid,
  input  logic                      out_data_ready,
  output logic [DATA_OUT_WIDTH-1:0] out_data,
  input  logic [DATA_REG_WIDTH-1:0] interp_reg
);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t                    state_q;
  logic [DATA_REG_WIDTH-1:0] cnt_q;
  logic [DATA_REG_WIDTH-1:0] nfac_q;
  logic [DATA_OUT_WIDTH-1:0] out_data_q;
  logic [DATA_OUT_WIDTH-1:0] sample_fit;
  logic [DATA_REG_WIDTH-1:0] cnt_d;
  logic                      out_fire;
  logic                      last_beat;
  logic                      in_accept;

  // Narrower outputs keep the sample MSBs; wider outputs zero-extend above the LSBs.
  generate
    if (DATA_OUT_WIDTH >= DATA_IN_WIDTH) begin : g_widen
      assign sample_fit = DATA_OUT_WIDTH'(in_data);
    end else begin : g_narrow
      assign sample_fit = in_data[DATA_IN_WIDTH-1 -: DATA_OUT_WIDTH];
    end
  endgenerate

  assign out_data_valid = (state_q == EMIT);
  assign out_data       = out_data_q;
  assign out_fire       = out_data_valid && out_data_ready;
  assign last_beat      = (cnt_q == nfac_q);
  // Ready looks through out_data_ready so a new group can follow the last beat with no bubble.
  assign in_data_ready  = rst_n && ((state_q == IDLE) || (out_fire && last_beat));
  assign in_accept      = in_data_valid && in_data_ready;
  assign cnt_d          = cnt_q + DATA_REG_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      nfac_q     <= '0;
      out_data_q <= '0;
    end else if (in_accept) begin
      state_q    <= EMIT;
      cnt_q      <= '0;
      nfac_q     <= interp_reg;
      out_data_q <= sample_fit;
    end else if (out_fire) begin
      if (last_beat) begin
        state_q <= IDLE;
      end else begin
        cnt_q <= cnt_d;
`ifdef DATA_INTERP_ZERO_STUFF_EN
        out_data_q <= '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_data_interpolation.sv
// Directed self-checking bench for data_interpolation (handshake, stalls, reset, width rules).
module tb_data_interpolation;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_data;
  logic [31:0] interp;

  logic        w_valid;
  logic [11:0] w16_in, w8_in;
  logic        w16_in_ready, w8_in_ready, w16_out_valid, w8_out_valid;
  logic [15:0] w16_out;
  logic [7:0]  w8_out;

  int checks = 0;
  int errors = 0;
  int beats;
  int guard;

  always #5 clk = ~clk;

  data_interpolation #(.DATA_IN_WIDTH(12), .DATA_OUT_WIDTH(12), .DATA_REG_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_data_valid(in_valid), .in_data_ready(in_ready),
    .in_data(in_data), .out_data_valid(out_valid), .out_data_ready(out_ready),
    .out_data(out_data), .interp_reg(interp));

  data_interpolation #(.DATA_IN_WIDTH(12), .DATA_OUT_WIDTH(16), .DATA_REG_WIDTH(32)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_data_valid(w_valid), .in_data_ready(w16_in_ready),
    .in_data(w16_in), .out_data_valid(w16_out_valid), .out_data_ready(1'b1),
    .out_data(w16_out), .interp_reg(32'd0));

  data_interpolation #(.DATA_IN_WIDTH(12), .DATA_OUT_WIDTH(8), .DATA_REG_WIDTH(32)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_data_valid(w_valid), .in_data_ready(w8_in_ready),
    .in_data(w8_in), .out_data_valid(w8_out_valid), .out_data_ready(1'b1),
    .out_data(w8_out), .interp_reg(32'd0));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] beat_val(input logic [11:0] s, input int k);
`ifdef DATA_INTERP_ZERO_STUFF_EN
    return (k == 0) ? s : 12'h000;
`else
    return s;
`endif
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; interp = '0;
    w_valid = 1'b0; w16_in = '0; w8_in = '0;
    step(); step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // pass-through, one sample per clock
    interp = 32'd0; in_valid = 1'b1; in_data = 12'h001;
    step();
    chk("pt_valid1", 32'(out_valid), 32'd1);
    chk("pt_data1", 32'(out_data), 32'h001);
    in_data = 12'h002;
    #1 chk("pt_ready1", 32'(in_ready), 32'd1);
    step();
    chk("pt_data2", 32'(out_data), 32'h002);
    in_data = 12'h003;
    #1 chk("pt_ready2", 32'(in_ready), 32'd1);
    step();
    chk("pt_data3", 32'(out_data), 32'h003);
    in_valid = 1'b0;
    #1 chk("pt_ready3", 32'(in_ready), 32'd1);
    step();
    chk("pt_idle", 32'(out_valid), 32'd0);

    // factor 3, two groups back to back
    interp = 32'd3; in_valid = 1'b1; in_data = 12'hABC;
    step();
    in_data = 12'h123;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("g1_valid", 32'(out_valid), 32'd1);
      chk("g1_data", 32'(out_data), 32'(beat_val(12'hABC, k)));
      chk("g1_in_ready", 32'(in_ready), (k == 3) ? 32'd1 : 32'd0);
      step();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("g2_valid", 32'(out_valid), 32'd1);
      chk("g2_data", 32'(out_data), 32'(beat_val(12'h123, k)));
      step();
    end
    chk("g2_idle", 32'(out_valid), 32'd0);

    // backpressure during beat 1
    interp = 32'd2; in_valid = 1'b1; in_data = 12'h5A5;
    step();
    in_valid = 1'b0;
    chk("bp_beat0", 32'(out_data), 32'(beat_val(12'h5A5, 0)));
    step();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_data", 32'(out_data), 32'(beat_val(12'h5A5, 1)));
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    chk("bp_beat2_valid", 32'(out_valid), 32'd1);
    chk("bp_beat2_data", 32'(out_data), 32'(beat_val(12'h5A5, 2)));
    step();
    chk("bp_idle", 32'(out_valid), 32'd0);

    // factor change mid-group only applies to the next group
    interp = 32'd2; in_valid = 1'b1; in_data = 12'h111;
    step();
    in_valid = 1'b0; interp = 32'd7;
    beats = 0; guard = 0;
    while (out_valid && guard < 20) begin beats++; guard++; step(); end
    chk("fac_old_beats", 32'(beats), 32'd3);
    in_valid = 1'b1; in_data = 12'h222;
    step();
    in_valid = 1'b0;
    beats = 0; guard = 0;
    while (out_valid && guard < 20) begin beats++; guard++; step(); end
    chk("fac_new_beats", 32'(beats), 32'd8);

    // reset in the middle of a 5-beat group
    interp = 32'd4; in_valid = 1'b1; in_data = 12'h333;
    step();
    in_valid = 1'b0;
    step(); step();
    chk("mr_pre_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    step();
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_data", 32'(out_data), 32'd0);
    chk("mr_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    step();
    chk("mr_no_beats", 32'(out_valid), 32'd0);
    interp = 32'd1; in_valid = 1'b1; in_data = 12'h444;
    step();
    in_valid = 1'b0;
    chk("mr_fresh_data", 32'(out_data), 32'h444);
    beats = 0; guard = 0;
    while (out_valid && guard < 20) begin beats++; guard++; step(); end
    chk("mr_fresh_beats", 32'(beats), 32'd2);

    // width rules
    w_valid = 1'b1; w16_in = 12'hFFF; w8_in = 12'hABC;
    step();
    w_valid = 1'b0;
    chk("w16_valid", 32'(w16_out_valid), 32'd1);
    chk("w16_data", 32'(w16_out), 32'h0FFF);
    chk("w8_data", 32'(w8_out), 32'h00AB);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
